// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the
// HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX
  } state_t;

  function automatic logic is_signed(
    input logic [2:0] op
  );
    return ~op[0];
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Radix-2 restoring divider core on
// unsigned operands, one step per cycle.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign shifted = {remainder, quotient[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  // high during the final step; results settle at its edge
  assign done    = run && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run       <= 1'b1;
      cnt       <= '0;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (run) begin
      quotient  <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
      remainder <= diff[WIDTH] ? shifted[WIDTH-1:0]
                               : diff[WIDTH-1:0];
      cnt       <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage multiply/divide unit owning HI/LO:
// pipelined multiplier with MAC and iterative divide.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mf_req,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW =
    (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  state_t           state, state_nxt;
  logic             accept, mt_any;
  logic [WIDTH-1:0] opa, opb;
  logic [2:0]       op_r;
  logic [CW-1:0]    mul_cnt;
  logic             dz, q_neg, r_neg;
  logic [W2-1:0]    ext_a, ext_b, prod, acc;
  logic [W2-1:0]    pp [MUL_STAGES];
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] core_q, core_r;
  logic             core_start, core_done;
  logic             wr_mul, wr_div, finish;

  assign mt_any = mthi | mtlo;
  assign busy   = (state != IDLE);
  assign accept = !busy && start && !cancel && !mt_any;
  assign stall  = (busy && (start | mf_req | mt_any))
               || (!busy && start && mt_any);

  assign ext_a = is_signed(op)
    ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b = is_signed(op)
    ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = ext_a * ext_b;

  always_comb begin
    acc = pp[MUL_STAGES-1];
    unique case (op_r)
      OP_MADD, OP_MADDU:
        acc = {hi, lo} + pp[MUL_STAGES-1];
      OP_MSUB, OP_MSUBU:
        acc = {hi, lo} - pp[MUL_STAGES-1];
      OP_MULT, OP_MULTU: ;
      default: ;
    endcase
  end

  assign abs_a = (is_signed(op_r) && opa[WIDTH-1])
    ? -opa : opa;
  assign abs_b = (is_signed(op_r) && opb[WIDTH-1])
    ? -opb : opb;

  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (core_start),
    .abort     (cancel),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    wr_mul     = 1'b0;
    wr_div     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE:
        if (accept)
          state_nxt = is_div(op) ? DIV_PREP : MUL;
      MUL:
        if (mul_cnt == CW'(MUL_STAGES-1)) begin
          wr_mul    = 1'b1;
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      DIV_PREP:
        if (opb == '0) begin
          state_nxt = DIV_FIX;
        end else begin
          core_start = 1'b1;
          state_nxt  = DIV_ITER;
        end
      DIV_ITER:
        if (core_done) state_nxt = DIV_FIX;
      DIV_FIX: begin
        wr_div    = !dz;
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a flush beats any completion in the same cycle
    if (cancel && busy) begin
      state_nxt  = IDLE;
      core_start = 1'b0;
      wr_mul     = 1'b0;
      wr_div     = 1'b0;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opa      <= '0;
      opb      <= '0;
      op_r     <= OP_MULT;
      mul_cnt  <= '0;
      dz       <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      for (int i = 0; i < MUL_STAGES; i++)
        pp[i] <= '0;
    end else begin
      done     <= finish;
      div_zero <= finish && dz && (state == DIV_FIX);
      if (accept) begin
        opa     <= a;
        opb     <= b;
        op_r    <= op;
        mul_cnt <= '0;
        pp[0]   <= prod;
      end else if (state == MUL) begin
        mul_cnt <= mul_cnt + CW'(1);
      end
      for (int i = 1; i < MUL_STAGES; i++)
        pp[i] <= pp[i-1];
      if (state == DIV_PREP) begin
        dz    <= (opb == '0);
        q_neg <= is_signed(op_r)
               & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_neg <= is_signed(op_r) & opa[WIDTH-1];
      end
      if (wr_mul) begin
        {hi, lo} <= acc;
      end else if (wr_div) begin
        hi <= r_neg ? -core_r : core_r;
        lo <= q_neg ? -core_q : core_q;
      end else if (!busy) begin
        if (mthi) hi <= a;
        if (mtlo) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit at
// 32/2 and 16/1 configurations.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        start = 0, mthi = 0, mtlo = 0;
  logic        mf_req = 0, cancel = 0;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic        busy, done, div_zero, stall;

  logic        s_start = 0, s_off = 0;
  logic [2:0]  s_op = 0;
  logic [15:0] s_a = 0, s_b = 0, s_hi, s_lo;
  logic        s_busy, s_done, s_dz, s_stall;

  muldiv_hilo_unit #(.WIDTH(32), .MUL_STAGES(2)) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .op(op), .a(a), .b(b), .mthi(mthi), .mtlo(mtlo),
    .mf_req(mf_req), .cancel(cancel), .hi(hi),
    .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero), .stall(stall)
  );

  muldiv_hilo_unit #(.WIDTH(16), .MUL_STAGES(1)) u_dut16 (
    .clock(clock), .reset(reset), .start(s_start),
    .op(s_op), .a(s_a), .b(s_b), .mthi(s_off),
    .mtlo(s_off), .mf_req(s_off), .cancel(s_off),
    .hi(s_hi), .lo(s_lo), .busy(s_busy),
    .done(s_done), .div_zero(s_dz), .stall(s_stall)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        q32[$], q16[$];
  int          cmp = 0, bad = 0, cyc = 0, t0 = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [15:0] s_mhi = 0, s_mlo = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string tag,
    input logic [63:0] got, input logic [63:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // returns {div_zero, hi, lo} for a w-bit unit
  function automatic logic [64:0] model(input int w,
    input logic [2:0] o, input logic [31:0] x,
    input logic [31:0] y, input logic [31:0] h,
    input logic [31:0] l);
    logic [63:0] wm, xe, ye, p, r, qv, rv;
    logic sg;
    longint sx, sy;
    wm = (64'd1 << w) - 64'd1;
    sg = ~o[0];
    xe = {32'd0, x} & wm;
    ye = {32'd0, y} & wm;
    if (sg && xe[w-1]) xe = xe | ~wm;
    if (sg && ye[w-1]) ye = ye | ~wm;
    if (o[2:1] == 2'b01) begin
      if (ye == 64'd0) return {1'b1, h, l};
      if (sg) begin
        sx = $signed(xe);
        sy = $signed(ye);
        qv = 64'(sx / sy);
        rv = 64'(sx % sy);
      end else begin
        qv = xe / ye;
        rv = xe % ye;
      end
      return {1'b0, 32'(rv & wm), 32'(qv & wm)};
    end
    p = xe * ye;
    r = ({32'd0, h} << w) | {32'd0, l};
    if (o[2:1] == 2'b10)      r = r + p;
    else if (o[2:1] == 2'b11) r = r - p;
    else                      r = p;
    return {1'b0, 32'((r >> w) & wm), 32'(r & wm)};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      check("done32_expected",
        64'(q32.size() != 0), 64'(1));
      if (q32.size() != 0) begin
        e = q32.pop_front();
        check("hi32", 64'(hi), 64'(e.hi));
        check("lo32", 64'(lo), 64'(e.lo));
        check("dz32", 64'(div_zero), 64'(e.dz));
      end
    end
    if (reset && s_done) begin
      check("done16_expected",
        64'(q16.size() != 0), 64'(1));
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("hi16", 64'(s_hi), 64'(e.hi));
        check("lo16", 64'(s_lo), 64'(e.lo));
        check("dz16", 64'(s_dz), 64'(e.dz));
      end
    end
  end

  task automatic launch(input logic [2:0] o,
    input logic [31:0] x, input logic [31:0] y,
    input bit track);
    logic [64:0] r;
    @(negedge clock);
    start = 1; op = o; a = x; b = y; t0 = cyc;
    if (track) begin
      r = model(32, o, x, y, m_hi, m_lo);
      q32.push_back('{hi: r[63:32], lo: r[31:0],
                      dz: r[64]});
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    @(negedge clock);
    start = 0;
  endtask

  task automatic finish_op(input int lat);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", 64'(done), 64'(1));
    if (done) check("latency", 64'(cyc - t0), 64'(lat));
  endtask

  task automatic mt(input logic wh, input logic wl,
    input logic [31:0] v);
    @(negedge clock);
    mthi = wh; mtlo = wl; a = v;
    @(negedge clock);
    mthi = 0; mtlo = 0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));

    launch(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1);
    check("mul_busy", 64'(busy), 64'(1));
    finish_op(3);
    check("mult_k", 64'({hi, lo}),
      64'hFFFF_FFFF_FFFF_FFFA);

    launch(OP_DIV, -32'sd7, 32'd2, 1);
    finish_op(35);
    check("div_k", 64'({hi, lo}),
      64'hFFFF_FFFF_FFFF_FFFD);

    launch(OP_DIVU, 32'd7, 32'd2, 1);
    finish_op(35);
    check("divu_k", 64'({hi, lo}),
      64'h0000_0001_0000_0003);

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    finish_op(35);
    check("divovf_k", 64'({hi, lo}),
      64'h0000_0000_8000_0000);

    mt(1, 1, 32'h11);
    mt(1, 0, 32'h11);
    mt(0, 1, 32'h22);
    launch(OP_DIVU, 32'd99, 32'd0, 1);
    finish_op(3);
    check("div0_flag", 64'(div_zero), 64'(1));
    check("div0_k", 64'({hi, lo}),
      64'h0000_0011_0000_0022);

    mt(1, 0, 32'd0);
    mt(0, 1, 32'd5);
    launch(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    finish_op(3);
    check("maddu_k", 64'({hi, lo}),
      64'hFFFF_FFFE_0000_0006);
    launch(OP_MSUB, 32'd1, 32'd6, 1);
    finish_op(3);
    check("msub_k", 64'({hi, lo}),
      64'hFFFF_FFFE_0000_0000);

    @(negedge clock);
    start = 1; op = OP_MULT; a = 32'h33; b = 32'd2;
    mtlo = 1;
    #1 check("collide_stall", 64'(stall), 64'(1));
    @(negedge clock);
    start = 0; mtlo = 0; m_lo = 32'h33;
    check("collide_busy", 64'(busy), 64'(0));
    check("collide_lo", 64'(lo), 64'(32'h33));
    repeat (4) @(negedge clock);

    launch(OP_DIVU, 32'd1000, 32'd7, 1);
    repeat (3) @(negedge clock);
    check("quiet_stall", 64'(stall), 64'(0));
    mf_req = 1;
    #1 check("mf_stall", 64'(stall), 64'(1));
    @(negedge clock);
    mf_req = 0; mthi = 1; a = 32'hDEAD;
    #1 check("mthi_stall", 64'(stall), 64'(1));
    @(negedge clock);
    mthi = 0;
    finish_op(35);
    check("busy_mt_k", 64'({hi, lo}),
      64'h0000_0006_0000_008E);

    launch(OP_DIVU, 32'h1234_5678, 32'd3, 0);
    repeat (10) @(negedge clock);
    check("cancel_busy_pre", 64'(busy), 64'(1));
    cancel = 1;
    @(negedge clock);
    cancel = 0;
    check("cancel_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clock);
    check("cancel_hi", 64'(hi), 64'(m_hi));
    check("cancel_lo", 64'(lo), 64'(m_lo));

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  o;
      logic [15:0] x, y;
      logic [64:0] r;
      int          lat, n, t1;
      o = 3'($urandom_range(0, 7));
      x = 16'($urandom);
      y = 16'($urandom);
      if (k % 8 == 3) y = 16'd0;
      if (k % 8 == 5) begin
        x = 16'h8000;
        y = 16'hFFFF;
      end
      @(negedge clock);
      s_start = 1; s_op = o; s_a = x; s_b = y;
      t1 = cyc;
      r = model(16, o, {16'd0, x}, {16'd0, y},
                {16'd0, s_mhi}, {16'd0, s_mlo});
      q16.push_back('{hi: r[63:32], lo: r[31:0],
                      dz: r[64]});
      s_mhi = r[47:32];
      s_mlo = r[15:0];
      lat = (o[2:1] == 2'b01) ? ((y == 0) ? 3 : 19) : 2;
      @(negedge clock);
      s_start = 0;
      n = 0;
      while (!s_done && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("sweep_lat",
        s_done ? 64'(cyc - t1) : 64'hFFFF, 64'(lat));
    end

    launch(OP_DIVU, 32'd100, 32'd3, 0);
    repeat (5) @(negedge clock);
    #2 reset = 0;
    #1;
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_dz", 64'(div_zero), 64'(0));
    check("arst_hi16", 64'(s_hi), 64'(0));
    check("arst_lo16", 64'(s_lo), 64'(0));
    check("left32", 64'(q32.size()), 64'(0));
    check("left16", 64'(q16.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      cmp, bad);
    $finish;
  end

endmodule
